cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Sequences the single common data bus (CDB) between five functional-unit requesters: LS, MULT0, MULT1, ALU, BRANCH.
- Each requester gets a 1-entry holding register, so a unit can hand off its result and move on.
- One winner per cycle goes to a registered CDB broadcast (tag, value, valid).
- Fixed priority, with a starvation-promotion counter per requester. Sits between the FU completion outputs and the RS/ROB/map-table CDB consumers.

Parameters:
- TAG_W, 3, width of the ROB/RS tag.
- STARVE_LIMIT, 4, cycles an occupied entry may wait ungranted before promotion to urgent (legal range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  synchronous flush (branch mispredict).
- req_valid  in  5  per-requester result valid. Index 0=LS, 1=MULT0, 2=MULT1, 3=ALU, 4=BRANCH.
- req_tag  in  5*TAG_W  per-requester tag; requester i at bits [i*TAG_W +: TAG_W].
- req_value  in  5*`XLEN  per-requester result; requester i at [i*`XLEN +: `XLEN].
- req_ready  out  5  holding entry i can accept this cycle.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_value  out  `XLEN  registered broadcast value.
- cdb_src  out  5  one-hot source of the current broadcast; 0 when cdb_valid=0.

Behaviour:
- Reset (async, active-high): all hold_valid=0, wait counters=0, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0. While reset is high, req_ready=5'b11111 (all entries empty).
- Holding entry i stores hold_valid, hold_tag and hold_value.
- Capture: at a rising edge with req_valid[i] & req_ready[i] & ~squash, the entry loads the tag and value and sets hold_valid.
- Grant is combinational from holding state only. There is no combinational path from req_valid to req_ready or grant.
  - Urgent set U = occupied entries with wait counter == STARVE_LIMIT.
  - If U is non-empty, grant the lowest index in U; otherwise grant the lowest occupied index.
  - Base priority order: LS > MULT0 > MULT1 > ALU > BRANCH.
- req_ready[i] = ~hold_valid[i] | grant[i].
  - A granted entry may be refilled at the same edge; the new result is held, not lost.
- Broadcast at each rising edge (no squash):
  - If any grant: cdb_valid=1, cdb_tag and cdb_value come from the granted entry, cdb_src=grant, and that entry's hold_valid is cleared (unless refilled).
  - If no grant: cdb_valid=0, cdb_src=0, and cdb_tag/cdb_value hold their previous values.
- Latency: a result captured at edge k is broadcast at edge k+1 at the earliest, so it is visible for the cycle after k+1. Each broadcast lasts exactly one cycle.
- Wait counter i:
  - Cleared when the entry is empty or granted.
  - Otherwise +1 per edge, saturating at STARVE_LIMIT.
  - A refill at grant time starts the counter at 0.
- Throughput is one broadcast per cycle. Each requester can sustain one result per cycle only if it wins every cycle.
- Bound: with STARVE_LIMIT=L, every occupied entry is granted within 5*(L+1) cycles.
- squash (synchronous, takes priority over capture and broadcast): at the edge, all hold_valid=0, counters=0, cdb_valid=0, cdb_src=0. Inputs presented in the squash cycle are dropped. req_ready stays combinational from state.
- Reset asserted mid-broadcast forces cdb_valid low immediately, without waiting for a clock edge.
- Tags are not checked for duplicates; ordering between different requesters is not guaranteed.

Test Plan:
- Reset then idle: assert reset mid-cycle with cdb_valid=1 → cdb_valid drops at once. After release: req_ready=5'b11111, cdb_valid=0 for 3 idle cycles.
- Single ALU result: tag=3, value=32'h0000_00AA captured at edge 1 → at edge 2 cdb_valid=1, cdb_tag=3, cdb_value=AA, cdb_src=5'b01000. At edge 3 cdb_valid=0.
- All five valid at edge 1 (tags 1..5), no further inputs → broadcasts in order LS(1), MULT0(2), MULT1(3), ALU(4), BRANCH(5) on edges 2..6. req_ready of each waiting entry stays 0 until its grant cycle.
- Starvation with STARVE_LIMIT=2: LS valid every cycle with tags alternating 6/7; BRANCH tag=5 captured at edge 1 → BRANCH wait counter reaches 2 and BRANCH is broadcast at edge 4, not later. LS is refilled every cycle it wins.
- Same-edge grant and refill: MULT0 holds tag 2 and is granted while req_valid[1]=1 with tag 6 → req_ready[1]=1. Tag 2 broadcasts at edge n, tag 6 at edge n+1. No result is lost.
- Squash: 3 entries occupied, cdb_valid=1, squash=1 for one cycle with req_valid[3]=1 → after the edge cdb_valid=0, all entries empty, and the ALU input is dropped (no broadcast of it ever).

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result requests and the registered CDB broadcast.
`ifndef XLEN
`define XLEN 32
`endif
interface cdb_arbiter_if #(parameter int TAG_W = 3);
  logic [4:0] req_valid;
  logic [4:0] req_ready;
  logic [5*TAG_W-1:0] req_tag;
  logic [5*`XLEN-1:0] req_value;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [`XLEN-1:0] cdb_value;
  logic [4:0] cdb_src;
  modport master(output req_valid, req_tag, req_value, input req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src);
  modport slave(input req_valid, req_tag, req_value, output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: five 1-entry holding registers arbitrated onto a registered CDB, fixed priority with starvation promotion.
`ifndef XLEN
`define XLEN 32
`endif
module cdb_arbiter #(
  parameter int TAG_W = 3,
  parameter int STARVE_LIMIT = 4
) (
  input logic clock,
  input logic reset,
  input logic squash,
  cdb_arbiter_if.slave bus
);
  localparam int N = 5;
  localparam int CW = 4;
  logic [N-1:0] hold_valid, urgent, grant, ready;
  logic [TAG_W-1:0] hold_tag [N];
  logic [`XLEN-1:0] hold_value [N];
  logic [CW-1:0] wait_cnt [N];
  logic [TAG_W-1:0] g_tag;
  logic [`XLEN-1:0] g_value;
  for (genvar g = 0; g < N; g++) begin : g_urg
    assign urgent[g] = hold_valid[g] && wait_cnt[g] == CW'(STARVE_LIMIT);
  end
  // lowest set bit of the urgent set, else of the occupied set
  assign grant = |urgent ? urgent & (~urgent + 5'd1) : hold_valid & (~hold_valid + 5'd1);
  assign ready = ~hold_valid | grant;
  assign bus.req_ready = ready;
  always_comb begin
    g_tag = '0;
    g_value = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        g_tag = hold_tag[i];
        g_value = hold_value[i];
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag <= '0;
      bus.cdb_value <= '0;
      bus.cdb_src <= '0;
      for (int i = 0; i < N; i++) begin
        hold_tag[i] <= '0;
        hold_value[i] <= '0;
        wait_cnt[i] <= '0;
      end
    end else if (squash) begin
      hold_valid <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_src <= '0;
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      bus.cdb_valid <= |grant;
      bus.cdb_src <= grant;
      if (|grant) begin
        bus.cdb_tag <= g_tag;
        bus.cdb_value <= g_value;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && ready[i]) begin
          hold_tag[i] <= bus.req_tag[i*TAG_W +: TAG_W];
          hold_value[i] <= bus.req_value[i*`XLEN +: `XLEN];
        end
        hold_valid[i] <= (bus.req_valid[i] && ready[i]) || (hold_valid[i] && !grant[i]);
        wait_cnt[i] <= (!hold_valid[i] || grant[i]) ? '0 : (urgent[i] ? wait_cnt[i] : wait_cnt[i] + 1'b1);
      end
    end
  end
endmodule
